decode_issue_stage: RTL and testbench

- Producer side of the ALU control/operand interface.
- Takes a fetched instruction and PC, decodes opcode, func3 and func7_5, generates the immediate, and selects ALU operand 1/2.
- Registers the result into an ID/EX pipeline register with a valid/ready handshake.
- Sits between fetch/register-file read and the ALU; converts the single-cycle datapath into a stallable, flushable pipeline stage.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/imm_gen.sv | 30 +++
 rtl/decode_issue_stage.sv | 173 +++++++++++++++++
 tb/tb_decode_issue_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared decode types and constants for the decode/issue stage.
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
  typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_SHAMT} op2_sel_e;

  // Width-independent control part of the issued bundle.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_5;
    logic [4:0] rd;
    logic       rf_we;
    logic       illegal;
  } issue_ctrl_t;

  // Canonical NOP (addi x0,x0,0) control word.
  localparam issue_ctrl_t CTRL_NOP = '{opcode: OPC_I, func3: 3'd0, func7_5: 1'b0,
                                       rd: 5'd0, rf_we: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the sign-extended immediate for the selected format.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [31:7]   instr_i,
  input  imm_sel_e      imm_sel_i,
  output logic [DW-1:0] imm_c
);

  logic [31:0] imm32;

  // Format-specific bit scatter, then sign-extend to the datapath width.
  always_comb begin
    imm32 = '0;
    unique case (imm_sel_i)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'h000};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_c = DW'($signed(imm32));
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes one instruction, selects ALU operands and holds
// the result in a stallable, flushable ID/EX register.
module decode_issue_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [31:0]   instr_i,
  input  logic [DW-1:0] pc_i,
  input  logic [DW-1:0] rs1_data_i,
  input  logic [DW-1:0] rs2_data_i,
  output logic [4:0]    rs1_addr_o,
  output logic [4:0]    rs2_addr_o,
  input  logic          flush_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [6:0]    opcode_o,
  output logic [2:0]    func3_o,
  output logic          func7_5_o,
  output logic [DW-1:0] alu_operand_1_o,
  output logic [DW-1:0] alu_operand_2_o,
  output logic [DW-1:0] cmp_a_o,
  output logic [DW-1:0] cmp_b_o,
  output logic [DW-1:0] imm_o,
  output logic [4:0]    rd_o,
  output logic          rf_we_o,
  output logic          illegal_o
);

  logic          valid_q, valid_d;
  issue_ctrl_t   ctrl_q, ctrl_d, ctrl_dec;
  logic [DW-1:0] op1_q, op1_d, op1_dec;
  logic [DW-1:0] op2_q, op2_d, op2_dec;
  logic [DW-1:0] cmp_a_q, cmp_a_d;
  logic [DW-1:0] cmp_b_q, cmp_b_d;
  logic [DW-1:0] imm_q, imm_d, imm_dec;
  logic [DW-1:0] imm_raw;
  imm_sel_e      imm_sel;
  op1_sel_e      op1_sel;
  op2_sel_e      op2_sel;
  logic          has_imm;
  logic          writes_rd;
  logic          accept;

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];
  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  imm_gen #(.DW(DW)) u_imm_gen (
    .instr_i   (instr_i[31:7]),
    .imm_sel_i (imm_sel),
    .imm_c     (imm_raw)
  );

  // Opcode decode into operand selects, immediate format and control flags.
  always_comb begin
    imm_sel   = IMM_I;
    op1_sel   = OP1_ZERO;
    op2_sel   = OP2_IMM;
    has_imm   = 1'b0;
    writes_rd = 1'b0;
    ctrl_dec  = '{opcode: instr_i[6:0], func3: instr_i[14:12], func7_5: 1'b0,
                  rd: instr_i[11:7], rf_we: 1'b0, illegal: 1'b0};
    unique case (instr_i[6:0])
      OPC_R: begin
        op1_sel = OP1_RS1; op2_sel = OP2_RS2; writes_rd = 1'b1;
        ctrl_dec.func7_5 = instr_i[30];
      end
      OPC_I: begin
        op1_sel = OP1_RS1; has_imm = 1'b1; writes_rd = 1'b1;
        // Shift-immediates carry func7 in imm[11:5]; only shamt feeds the ALU.
        if (instr_i[13:12] == 2'b01) op2_sel = OP2_SHAMT;
        ctrl_dec.func7_5 = (instr_i[14:12] == 3'b101) && instr_i[30];
      end
      OPC_LOAD, OPC_JALR: begin
        op1_sel = OP1_RS1; has_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_STORE: begin
        op1_sel = OP1_RS1; imm_sel = IMM_S; has_imm = 1'b1;
      end
      OPC_BRANCH: begin
        op1_sel = OP1_PC; imm_sel = IMM_B; has_imm = 1'b1;
      end
      OPC_LUI: begin
        imm_sel = IMM_U; has_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        op1_sel = OP1_PC; imm_sel = IMM_U; has_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_JAL: begin
        op1_sel = OP1_PC; imm_sel = IMM_J; has_imm = 1'b1; writes_rd = 1'b1;
      end
      default: ctrl_dec.illegal = 1'b1;
    endcase
    ctrl_dec.rf_we = writes_rd && (instr_i[11:7] != 5'd0);
    // R-type and unsupported opcodes carry no immediate; report zero.
    imm_dec = has_imm ? imm_raw : '0;
    unique case (op1_sel)
      OP1_RS1: op1_dec = rs1_data_i;
      OP1_PC:  op1_dec = pc_i;
      default: op1_dec = '0;
    endcase
    unique case (op2_sel)
      OP2_RS2:   op2_dec = rs2_data_i;
      OP2_SHAMT: op2_dec = DW'(instr_i[24:20]);
      default:   op2_dec = imm_dec;
    endcase
  end

  // Pipeline register next state: flush beats accept, accept beats drain.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    imm_d   = imm_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_dec;
      op1_d   = op1_dec;
      op2_d   = op2_dec;
      cmp_a_d = rs1_data_i;
      cmp_b_d = rs2_data_i;
      imm_d   = imm_dec;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX register with synchronous reset to an invalid NOP bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
      cmp_a_q <= '0;
      cmp_b_q <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cmp_a_q <= cmp_a_d;
      cmp_b_q <= cmp_b_d;
      imm_q   <= imm_d;
    end
  end

  assign out_valid_o     = valid_q;
  assign opcode_o        = ctrl_q.opcode;
  assign func3_o         = ctrl_q.func3;
  assign func7_5_o       = ctrl_q.func7_5;
  assign rd_o            = ctrl_q.rd;
  assign rf_we_o         = ctrl_q.rf_we;
  assign illegal_o       = ctrl_q.illegal;
  assign alu_operand_1_o = op1_q;
  assign alu_operand_2_o = op2_q;
  assign cmp_a_o         = cmp_a_q;
  assign cmp_b_o         = cmp_b_q;
  assign imm_o           = imm_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: reference model plus directed literal checks.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] instr_i = 32'h0;
  logic [31:0] pc_i = 32'h0;
  logic [31:0] rs1_data_i = 32'h0;
  logic [31:0] rs2_data_i = 32'h0;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [6:0]  opcode_o;
  logic [2:0]  func3_o;
  logic        func7_5_o;
  logic [31:0] alu_operand_1_o, alu_operand_2_o, cmp_a_o, cmp_b_o, imm_o;
  logic [4:0]  rd_o;
  logic        rf_we_o, illegal_o;

  int n_checks = 0;
  int n_errs   = 0;

  decode_issue_stage #(.DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .opcode_o(opcode_o),
    .func3_o(func3_o), .func7_5_o(func7_5_o), .alu_operand_1_o(alu_operand_1_o),
    .alu_operand_2_o(alu_operand_2_o), .cmp_a_o(cmp_a_o), .cmp_b_o(cmp_b_o),
    .imm_o(imm_o), .rd_o(rd_o), .rf_we_o(rf_we_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        f75;
    logic [31:0] op1, op2, ca, cb, imm;
    logic [4:0]  rd;
    logic        we, ill;
  } exp_t;

  function automatic exp_t nop_bundle();
    exp_t e;
    e.opcode = 7'h13; e.func3 = 3'd0; e.f75 = 1'b0;
    e.op1 = 0; e.op2 = 0; e.ca = 0; e.cb = 0; e.imm = 0;
    e.rd = 5'd0; e.we = 1'b0; e.ill = 1'b0;
    return e;
  endfunction

  // Reference decode built from the instruction-set rules with plain arithmetic.
  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc,
                                 logic [31:0] r1, logic [31:0] r2);
    exp_t e;
    logic signed [31:0] si;
    logic [31:0] iimm, simm, bimm, uimm, jimm, sgn;
    si   = $signed(ins);
    sgn  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    iimm = 32'(si >>> 20);
    simm = ((iimm >> 5) << 5) | 32'(ins[11:7]);
    bimm = (sgn & 32'hFFFF_F000) + (32'(ins[7]) << 11) + (32'(ins[30:25]) << 5)
         + (32'(ins[11:8]) << 1);
    uimm = ins & 32'hFFFF_F000;
    jimm = (sgn & 32'hFFF0_0000) + (32'(ins[19:12]) << 12) + (32'(ins[20]) << 11)
         + (32'(ins[30:21]) << 1);
    e.opcode = ins[6:0]; e.func3 = ins[14:12]; e.rd = ins[11:7];
    e.ca = r1; e.cb = r2; e.f75 = 1'b0; e.ill = 1'b0; e.we = 1'b1;
    e.op1 = 0; e.op2 = 0; e.imm = 0;
    case (ins[6:0])
      7'h33: begin e.op1 = r1; e.op2 = r2; e.f75 = ins[30]; end
      7'h13: begin
        e.op1 = r1; e.imm = iimm;
        e.op2 = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? (ins >> 20) & 32'h1F : iimm;
        e.f75 = (ins[14:12] == 3'd5) ? ins[30] : 1'b0;
      end
      7'h03, 7'h67: begin e.op1 = r1; e.op2 = iimm; e.imm = iimm; end
      7'h23: begin e.op1 = r1; e.op2 = simm; e.imm = simm; e.we = 1'b0; end
      7'h63: begin e.op1 = pc; e.op2 = bimm; e.imm = bimm; e.we = 1'b0; end
      7'h37: begin e.op2 = uimm; e.imm = uimm; end
      7'h17: begin e.op1 = pc; e.op2 = uimm; e.imm = uimm; end
      7'h6F: begin e.op1 = pc; e.op2 = jimm; e.imm = jimm; end
      default: begin e.ill = 1'b1; e.we = 1'b0; end
    endcase
    if (ins[11:7] == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  exp_t m = nop_bundle();
  logic m_valid = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on each rising edge from the inputs presented there.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m = nop_bundle();
    end else if (flush_i) begin
      m_valid = 1'b0;
    end else if (in_valid_i && (!m_valid || out_ready_i)) begin
      m_valid = 1'b1;
      m = model(instr_i, pc_i, rs1_data_i, rs2_data_i);
    end else if (out_ready_i) begin
      m_valid = 1'b0;
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid_o), 32'(m_valid));
    chk("in_ready", 32'(in_ready_o), 32'(!m_valid || out_ready_i));
    chk("rs1_addr", 32'(rs1_addr_o), 32'(instr_i[19:15]));
    chk("rs2_addr", 32'(rs2_addr_o), 32'(instr_i[24:20]));
    chk("opcode", 32'(opcode_o), 32'(m.opcode));
    chk("func3", 32'(func3_o), 32'(m.func3));
    chk("func7_5", 32'(func7_5_o), 32'(m.f75));
    chk("op1", alu_operand_1_o, m.op1);
    chk("op2", alu_operand_2_o, m.op2);
    chk("cmp_a", cmp_a_o, m.ca);
    chk("cmp_b", cmp_b_o, m.cb);
    chk("imm", imm_o, m.imm);
    chk("rd", 32'(rd_o), 32'(m.rd));
    chk("rf_we", 32'(rf_we_o), 32'(m.we));
    chk("illegal", 32'(illegal_o), 32'(m.ill));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] ins, logic [31:0] pc,
                       logic [31:0] r1, logic [31:0] r2, logic ordy, logic fl);
    in_valid_i = v; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    out_ready_i = ordy; flush_i = fl;
  endtask

  logic [31:0] tbl [7] = '{32'h00500013, 32'h00001297, 32'h004100E7, 32'h00C0A183,
                           32'h40208233, 32'hFE209EE3, 32'h01F09093};

  initial begin
    step(); step();
    chk("rst valid", 32'(out_valid_o), 32'd0);
    chk("rst opcode", 32'(opcode_o), 32'h13);
    chk("rst op1", alu_operand_1_o, 32'd0);

    rst_n = 1'b1;
    drive(1, 32'h002081B3, 32'h40, 5, 7, 1, 0);  // add x3,x1,x2
    step();
    chk("add valid", 32'(out_valid_o), 32'd1);
    chk("add opcode", 32'(opcode_o), 32'h33);
    chk("add op1", alu_operand_1_o, 32'd5);
    chk("add op2", alu_operand_2_o, 32'd7);
    chk("add rd", 32'(rd_o), 32'd3);
    chk("add rf_we", 32'(rf_we_o), 32'd1);
    chk("add f75", 32'(func7_5_o), 32'd0);

    drive(1, 32'h40435293, 32'h44, 32'h80000000, 0, 1, 0);  // srai x5,x6,4
    step();
    chk("srai func3", 32'(func3_o), 32'd5);
    chk("srai f75", 32'(func7_5_o), 32'd1);
    chk("srai op2", alu_operand_2_o, 32'h4);
    chk("srai imm", imm_o, 32'h404);

    drive(1, 32'hFE208CE3, 32'h100, 9, 9, 1, 0);  // beq x1,x2,-8
    step();
    chk("beq op1", alu_operand_1_o, 32'h100);
    chk("beq op2", alu_operand_2_o, 32'hFFFFFFF8);
    chk("beq cmp_a", cmp_a_o, 32'd9);
    chk("beq cmp_b", cmp_b_o, 32'd9);
    chk("beq rf_we", 32'(rf_we_o), 32'd0);

    drive(1, 32'h123453B7, 32'h104, 1, 2, 1, 0);  // lui x7,0x12345
    step();
    chk("lui op1", alu_operand_1_o, 32'd0);
    chk("lui op2", alu_operand_2_o, 32'h12345000);
    drive(1, 32'h0020A423, 32'h108, 32'h1000, 32'h55, 1, 0);  // sw x2,8(x1)
    step();
    chk("sw valid", 32'(out_valid_o), 32'd1);
    chk("sw op2", alu_operand_2_o, 32'd8);
    chk("sw rf_we", 32'(rf_we_o), 32'd0);

    drive(1, 32'h00100213, 32'h10C, 0, 0, 0, 0);  // addi x4,x0,1 under backpressure
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp in_ready", 32'(in_ready_o), 32'd0);
      chk("bp opcode", 32'(opcode_o), 32'h23);
      chk("bp op2", alu_operand_2_o, 32'd8);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp release in_ready", 32'(in_ready_o), 32'd1);
    step();
    chk("bp accept opcode", 32'(opcode_o), 32'h13);
    chk("bp accept op2", alu_operand_2_o, 32'd1);
    chk("bp accept rd", 32'(rd_o), 32'd4);

    drive(1, 32'h002081B3, 32'h110, 1, 1, 0, 1);  // flush a held bundle
    step();
    chk("flush held valid", 32'(out_valid_o), 32'd0);
    drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
    step();
    chk("post flush valid", 32'(out_valid_o), 32'd0);
    drive(1, 32'h123453B7, 32'h114, 0, 0, 1, 1);  // flush drops acceptable input
    step();
    chk("flush drop valid", 32'(out_valid_o), 32'd0);
    chk("flush drop opcode", 32'(opcode_o), 32'h13);

    drive(1, 32'h010000EF, 32'h200, 0, 0, 1, 0);  // jal x1,16
    step();
    chk("jal op1", alu_operand_1_o, 32'h200);
    chk("jal op2", alu_operand_2_o, 32'd16);
    drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
    step();
    rst_n = 1'b0;
    step();
    chk("midrst valid", 32'(out_valid_o), 32'd0);
    chk("midrst opcode", 32'(opcode_o), 32'h13);
    chk("midrst op1", alu_operand_1_o, 32'd0);
    rst_n = 1'b1;

    drive(1, 32'h000002FF, 32'h300, 3, 4, 1, 0);  // unsupported opcode 0x7F
    step();
    chk("ill valid", 32'(out_valid_o), 32'd1);
    chk("ill flag", 32'(illegal_o), 32'd1);
    chk("ill rf_we", 32'(rf_we_o), 32'd0);
    chk("ill op1", alu_operand_1_o, 32'd0);
    chk("ill op2", alu_operand_2_o, 32'd0);

    // Mixed opcodes with intermittent backpressure, checked by the model.
    for (int i = 0; i < 14; i++) begin
      drive(1, tbl[i % 7], 32'h400 + 32'(i * 4), 32'(i + 10), 32'(i + 20), (i % 3) != 1, 0);
      step();
    end
    drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
